alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised successor to the combinational ALU: an XLEN-wide ALU with valid/ready handshakes on both sides.
//  Base ops complete in 1 cycle. Unsigned multiply/divide (RV32M subset) runs iteratively over XLEN cycles.
//  Sits between decode and writeback for the multi-cycle core. Decode stalls on in_ready, writeback consumes on out_valid.
// PARAMETERS
//  XLEN      32             operand/result width, >=8, power of 2
//  SHAMT_W   $clog2(XLEN)   shift-amount bits taken from in_b[SHAMT_W-1:0]
//  MULDIV_EN 1              0: opcodes 1010-1101 behave as reserved
// PORTS
//  clk         in   1     single clock, rising edge
//  rst_n       in   1     asynchronous, active-low reset
//  in_valid    in   1     operation request
//  in_ready    out  1     ALU can accept; high only in IDLE
//  alu_opcode  in   4     operation select, sampled on accept
//  in_a        in   XLEN  operand A, sampled on accept
//  in_b        in   XLEN  operand B, sampled on accept
//  out_valid   out  1     alu_out holds a result
//  out_ready   in   1     consumer takes result
//  alu_out     out  XLEN  registered result
//  busy        out  1     high in CALC or DONE
// BEHAVIOUR
//  Opcodes:
//   0000 AND, 0001 XOR, 0010 OR, 0011 ADD, 0100 SUB
//   0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT (signed), 1001 SLTU
//   1010 MUL (low XLEN), 1011 MULHU (high XLEN), 1100 DIVU, 1101 REMU
//   1110, 1111 reserved: result 0, latency 1
//  Reset (rst_n=0, any time, incl. mid-CALC): state=IDLE, in_ready=1, out_valid=0, alu_out=0, busy=0.
//   All operand, counter and partial registers clear. The in-flight op is discarded, with no result.
//  Accept: in_valid && in_ready at a rising edge. Opcode and operands are latched, so later input changes are ignored.
//  FSM IDLE -> DONE: base op or reserved op. Result is registered at the accept edge, so out_valid is high the next cycle (latency 1).
//  FSM IDLE -> CALC: MUL/MULHU/DIVU/REMU with MULDIV_EN=1.
//   Counter loads XLEN-1. One iteration per cycle.
//   MUL/MULHU: shift-add, 2*XLEN-bit accumulator.
//   DIVU/REMU: restoring division, XLEN-bit quotient and remainder.
//  FSM CALC -> DONE: when the counter reaches 0. The result is written on that edge, so out_valid rises exactly XLEN+1 cycles after accept.
//  FSM DONE -> IDLE: on out_ready. out_valid drops the next cycle. in_ready rises the same cycle.
//  No overlap: a new op is never accepted in CALC or DONE, and in_ready is not combinationally tied to out_ready.
//  Backpressure: while out_valid && !out_ready, alu_out is held stable.
//  Divide by zero (in_b==0) takes the 1-cycle path:
//   DIVU -> all ones. REMU -> in_a.
//  Shifts use in_b[SHAMT_W-1:0] only. SRA sign-fills from in_a[XLEN-1].
//  Arithmetic: ADD/SUB wrap modulo 2^XLEN, with no flags. SLT/SLTU return 1 or 0, zero-extended.
// STRUCTURE
//  Package alu_pkg:
//   opcode localparams OP_AND..OP_REMU
//   state encoding ST_IDLE/ST_CALC/ST_DONE
//   function is_muldiv(op)
//  Sub-module alu_muldiv_core (iterative multiply/divide datapath):
//   inputs start, op, a, b
//   outputs done, result
//   counter owned by the core
//  Top holds the FSM, handshakes, base-op combinational logic and the result register.
// TESTING
//  AND A=AAAA5555 B=5555AAAA -> alu_out=00000000, out_valid 1 cycle after accept.
//   Then XOR on the same operands -> FFFFFFFF.
//  MUL 0000FFFF*00010001 -> FFFFFFFF.
//   MULHU FFFFFFFF*FFFFFFFF -> FFFFFFFE.
//   out_valid exactly 33 cycles after accept. in_ready=0 throughout.
//  DIVU 00000064/00000007 -> 0000000E. REMU on the same operands -> 00000002.
//   DIVU x/0 -> FFFFFFFF in 1 cycle. REMU 5/0 -> 00000005.
//  SRA 80000000 by in_b=00000024 (shamt 4) -> F8000000.
//   SLT FFFFFFFF,00000001 -> 1. SLTU with the same operands -> 0.
//  Hold out_ready=0 for 5 cycles in DONE -> alu_out stable, in_ready=0, busy=1.
//   Raise out_ready -> out_valid drops next cycle.
//  Assert rst_n=0 at CALC iteration 10 -> outputs go to reset values immediately, with no out_valid.
//   The next ADD 1+2 -> 00000003.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   - 4-bit opcode constants (OP_AND .. OP_REMU)
//   - FSM state encoding for the top-level control
//   - is_muldiv(): true for the iterative multiply/divide opcodes
//   - is_div():    true for DIVU/REMU (used for divide-by-zero bypass)
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_XOR   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative unsigned multiply / divide datapath, one bit per cycle.
//   clk, rst_n : clock, async active-low reset (clears all state)
//   start      : load operands and begin (XLEN iterations follow)
//   op         : OP_MUL / OP_MULHU / OP_DIVU / OP_REMU
//   a, b       : operands, sampled on start
//   done       : high during the final iteration cycle
//   result     : valid while done is high (value after the final step)
//
// The same hi/lo register pair serves both operations:
//   multiply: {hi,lo} is the 2*XLEN accumulator, lo starts as the multiplier
//             and is shifted out LSB first while partial sums enter hi.
//   divide:   hi is the running remainder, lo starts as the dividend and is
//             shifted left while quotient bits enter at the bottom.
// m holds the multiplicand (multiply) or the divisor (divide).
module alu_muldiv_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    logic             active;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q;
    logic [XLEN-1:0]  hi;
    logic [XLEN-1:0]  lo;
    logic [XLEN-1:0]  m;

    logic             div_op;
    logic [XLEN:0]    mul_sum;
    logic [XLEN:0]    rs;
    logic             ge;
    logic [XLEN-1:0]  rs_sub;
    logic [XLEN-1:0]  hi_n;
    logic [XLEN-1:0]  lo_n;

    assign div_op = is_div(op_q);

    // Shift-add step: conditionally add multiplicand into the upper half,
    // carry included, then shift the whole accumulator right by one.
    assign mul_sum = {1'b0, hi} + {1'b0, (lo[0] ? m : {XLEN{1'b0}})};

    // Restoring-division step: shift the next dividend bit into the
    // remainder; subtract the divisor if it fits. rs can be XLEN+1 bits wide,
    // but when it is >= m the difference is < m, so XLEN bits suffice.
    assign rs     = {hi, lo[XLEN-1]};
    assign ge     = (rs >= {1'b0, m});
    assign rs_sub = rs[XLEN-1:0] - m;

    always_comb begin
        hi_n = '0;
        lo_n = '0;
        if (div_op) begin
            hi_n = ge ? rs_sub : rs[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], ge};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    assign done = active && (cnt == '0);

    always_comb begin
        result = '0;
        case (op_q)
            OP_MUL:   result = lo_n;
            OP_MULHU: result = hi_n;
            OP_DIVU:  result = lo_n;
            OP_REMU:  result = hi_n;
            default:  result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
            op_q   <= '0;
            hi     <= '0;
            lo     <= '0;
            m      <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= CNT_W'(XLEN - 1);
            op_q   <= op;
            hi     <= '0;
            lo     <= is_div(op) ? a : b;
            m      <= is_div(op) ? b : a;
        end else if (active) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides.
//   clk, rst_n  : clock, async active-low reset
//   in_valid    : request; accepted when in_valid && in_ready at a rising edge
//   in_ready    : high only in IDLE
//   alu_opcode  : operation select (latched on accept)
//   in_a, in_b  : operands (latched on accept)
//   out_valid   : alu_out holds a result (DONE state)
//   out_ready   : consumer takes result; returns FSM to IDLE
//   alu_out     : registered result, held stable while out_valid
//   busy        : high in CALC or DONE
//
// Base ops, reserved opcodes and divide-by-zero are computed combinationally
// from the inputs and registered at the accept edge (latency 1). Multiply and
// divide go through alu_muldiv_core and write alu_out on its final iteration.
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int SHAMT_W   = $clog2(XLEN),
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_opcode,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out,
    output logic            busy
);

    state_t              state;
    state_t              state_nx;

    logic                accept;
    logic                div_zero;
    logic                go_calc;
    logic                core_start;
    logic                core_done;
    logic [XLEN-1:0]     core_result;
    logic [XLEN-1:0]     base_res;
    logic [SHAMT_W-1:0]  shamt;

    // Handshake outputs decode the registered state only, so in_ready never
    // depends combinationally on out_ready.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    assign accept     = in_valid && in_ready;
    assign div_zero   = is_div(alu_opcode) && (in_b == '0);
    assign go_calc    = MULDIV_EN && is_muldiv(alu_opcode) && !div_zero;
    assign core_start = accept && go_calc;
    assign shamt      = in_b[SHAMT_W-1:0];

    generate
        if (MULDIV_EN) begin : g_muldiv
            alu_muldiv_core #(
                .XLEN   (XLEN)
            ) u_core (
                .clk    (clk),
                .rst_n  (rst_n),
                .start  (core_start),
                .op     (alu_opcode),
                .a      (in_a),
                .b      (in_b),
                .done   (core_done),
                .result (core_result)
            );
        end else begin : g_no_muldiv
            assign core_done   = 1'b0;
            assign core_result = '0;
        end
    endgenerate

    // Single-cycle results. DIVU/REMU only reach here with a zero divisor;
    // with MULDIV_EN=0 all four muldiv opcodes fall to the reserved default.
    always_comb begin
        base_res = '0;
        case (alu_opcode)
            OP_AND:  base_res = in_a & in_b;
            OP_XOR:  base_res = in_a ^ in_b;
            OP_OR:   base_res = in_a | in_b;
            OP_ADD:  base_res = in_a + in_b;
            OP_SUB:  base_res = in_a - in_b;
            OP_SLL:  base_res = in_a << shamt;
            OP_SRL:  base_res = in_a >> shamt;
            OP_SRA:  base_res = $signed(in_a) >>> shamt;
            OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            OP_DIVU: if (MULDIV_EN) base_res = '1;
            OP_REMU: if (MULDIV_EN) base_res = in_a;
            default: base_res = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept)    state_nx = go_calc ? ST_CALC : ST_DONE;
            ST_CALC: if (core_done) state_nx = ST_DONE;
            ST_DONE: if (out_ready) state_nx = ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out <= '0;
        end else if (accept && !go_calc) begin
            alu_out <= base_res;
        end else if ((state == ST_CALC) && core_done) begin
            alu_out <= core_result;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_opcode;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_out;
    logic            busy;

    alu_seq #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_opcode (alu_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_out    (alu_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
        int          hold;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference behaviour straight from the opcode table.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned p;
        logic [63:0]     sx;
        int              sh;
        sh = int'(b % 32);
        p  = longint'(a) * longint'(b);
        sx = {{32{a[31]}}, a};
        case (op)
            4'd0:  return a & b;
            4'd1:  return a ^ b;
            4'd2:  return a | b;
            4'd3:  return a + b;
            4'd4:  return a - b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return 32'(sx >> sh);
            4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'd10 || op == 4'd11) return XLEN + 1;
        if ((op == 4'd12 || op == 4'd13) && b != 0) return XLEN + 1;
        return 1;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        do begin
            @(posedge clk);
            #1;
        end while (!in_ready);
        in_valid   = 1'b1;
        alu_opcode = op;
        in_a       = a;
        in_b       = b;
        e.res  = model(op, a, b);
        e.lat  = model_lat(op, b);
        e.acc  = cyc + 1;
        e.hold = hold;
        q.push_back(e);
        n_vec++;
        @(posedge clk);
        #1;
        // Scramble inputs after accept: results must come from latched values.
        in_valid   = 1'b0;
        alu_opcode = 4'($urandom_range(0, 15));
        in_a       = $urandom;
        in_b       = $urandom;
    endtask

    // Monitor / consumer: owns out_ready, checks every cycle against the queue head.
    initial begin
        int lat;
        int held;
        logic bsy;
        held = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                bsy = (q.size() != 0) && (cyc >= q[0].acc);
                check("in_ready", 32'(in_ready), 32'(!bsy));
                check("busy", 32'(busy), 32'(bsy));
                if (!bsy) begin
                    check("out_valid_idle", 32'(out_valid), 32'd0);
                    out_ready = 1'($urandom_range(0, 1));
                end else begin
                    lat = cyc + 1 - q[0].acc;
                    if (lat < q[0].lat) begin
                        check("out_valid_early", 32'(out_valid), 32'd0);
                        out_ready = 1'($urandom_range(0, 1));
                    end else begin
                        check("out_valid", 32'(out_valid), 32'd1);
                        check("alu_out", alu_out, q[0].res);
                        if (held < q[0].hold) begin
                            out_ready = 1'b0;
                            held++;
                        end else begin
                            out_ready = (q[0].hold > 0) ? 1'b1 : 1'($urandom_range(0, 1));
                            if (out_ready) begin
                                void'(q.pop_front());
                                held = 0;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog: cycle budget exhausted with %0d results pending", q.size());
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    logic [3:0]  d_op[15] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd12, 4'd13, 4'd12, 4'd13,
                              4'd7, 4'd8, 4'd9, 4'd3, 4'd10, 4'd14, 4'd15};
    logic [31:0] d_a[15]  = '{32'hAAAA5555, 32'hAAAA5555, 32'h0000FFFF, 32'hFFFFFFFF,
                              32'h00000064, 32'h00000064, 32'h12345678, 32'h00000005,
                              32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h00001234, 32'hDEADBEEF, 32'h12345678};
    logic [31:0] d_b[15]  = '{32'h5555AAAA, 32'h5555AAAA, 32'h00010001, 32'hFFFFFFFF,
                              32'h00000007, 32'h00000007, 32'h00000000, 32'h00000000,
                              32'h00000024, 32'h00000001, 32'h00000001, 32'h00000001,
                              32'h00005678, 32'h00000001, 32'h00000002};
    int          d_hold[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 0, 0};

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        alu_opcode = '0;
        in_a       = '0;
        in_b       = '0;
        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset alu_out", alu_out, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            issue(d_op[i], d_a[i], d_b[i], d_hold[i]);
        end

        // Reset mid-CALC: the MUL is dropped without a result.
        issue(4'd10, 32'h0001_0003, 32'h0000_0101, 0);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        q.delete();
        check("midcalc rst out_valid", 32'(out_valid), 32'd0);
        check("midcalc rst in_ready", 32'(in_ready), 32'd1);
        check("midcalc rst busy", 32'(busy), 32'd0);
        check("midcalc rst alu_out", alu_out, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(4'd3, 32'd1, 32'd2, 0);

        for (int i = 0; i < 70; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 40));
                default: b = $urandom;
            endcase
            issue(op, a, b, ($urandom_range(0, 7) == 0) ? 2 : 0);
        end

        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results still pending, required 0", q.size());
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
